// File: rtl/sseg_scan_controller_if.sv
// Bundle of load, enable and digit-select signals between the scan controller
// and its neighbours (register source on one side, sseg driver on the other).
interface sseg_scan_controller_if;
    logic        load;
    logic [31:0] load_data;
    logic [7:0]  load_dp;
    logic [7:0]  digit_en;
    logic [2:0]  active_digit;
    logic [3:0]  num;
    logic        dp_ctrl;
    logic        blank;
    logic        frame_done;

    modport master (
        output load, load_data, load_dp, digit_en,
        input  active_digit, num, dp_ctrl, blank, frame_done
    );

    modport slave (
        input  load, load_data, load_dp, digit_en,
        output active_digit, num, dp_ctrl, blank, frame_done
    );
endinterface

// File: rtl/sseg_scan_controller.sv
// Time-multiplexed scan over eight seven-segment digits: a prescaler sets the
// dwell, a pointer walks the enabled digits, and the selected nibble/dp is muxed out.
module sseg_scan_controller #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    sseg_scan_controller_if.slave       bus
);

    localparam logic [23:0] CNT_LAST = 24'(TICK_DIV - 1);

    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  dp_q, dp_d;
    logic        frame_done_q, frame_done_d;

    logic        tick;
    logic        any_en;
    logic [2:0]  ptr_next;
    logic [2:0]  idx;
    logic        found;

    assign tick   = (cnt_q == CNT_LAST);
    assign any_en = |bus.digit_en;

    // First enabled digit above ptr, wrapping 7->0; holds if none but ptr itself.
    always_comb begin
        ptr_next = ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int i = 1; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && bus.digit_en[idx]) begin
                ptr_next = idx;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d        = tick ? 24'd0 : cnt_q + 24'd1;
        ptr_d        = tick ? ptr_next : ptr_q;
        data_d       = bus.load ? bus.load_data : data_q;
        dp_d         = bus.load ? bus.load_dp : dp_q;
        frame_done_d = tick && any_en && (ptr_next <= ptr_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            ptr_q        <= '0;
            data_q       <= '0;
            dp_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            data_q       <= data_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.active_digit = ptr_q;
    assign bus.num          = data_q[{ptr_q, 2'b00} +: 4];
    assign bus.dp_ctrl      = dp_q[ptr_q];
    assign bus.blank        = ~bus.digit_en[ptr_q];
    assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with TICK_DIV=4: a vector table walks
// scan, skip, all-off, dp, load-on-tick and reset cases, then two hand sequences.
module tb_sseg_scan_controller;

    logic clk = 1'b0;
    logic reset;

    sseg_scan_controller_if bus();

    sseg_scan_controller #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  en;
        int          ncyc;
        logic [2:0]  e_act;
        logic [3:0]  e_num;
        logic        e_dp;
        logic        e_blank;
        logic        e_fd;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic ld, input logic [31:0] data,
                       input logic [7:0] dp, input logic [7:0] en, input int ncyc,
                       input logic [2:0] act, input logic [3:0] num, input logic dpc,
                       input logic blk, input logic fd);
        vec_t v;
        v.rst = rst; v.ld = ld; v.data = data; v.dp = dp; v.en = en; v.ncyc = ncyc;
        v.e_act = act; v.e_num = num; v.e_dp = dpc; v.e_blank = blk; v.e_fd = fd;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    localparam logic [31:0] D = 32'h7654_3210;

    initial begin
        int fd_cnt;
        reset         = 1'b0;
        bus.load      = 1'b0;
        bus.load_data = '0;
        bus.load_dp   = '0;
        bus.digit_en  = 8'hFF;

        //  rst ld data          dp     en     n  act num dp blk fd
        add(1, 0, D,            8'h00, 8'hFF, 1, 0, 0,  0, 0, 0);
        add(0, 1, D,            8'h00, 8'hFF, 1, 0, 0,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 3, 1, 1,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 3, 1, 1,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 1, 2, 2,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 4, 3, 3,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 4, 4, 4,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 4, 5, 5,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 4, 6, 6,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 4, 7, 7,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 4, 0, 0,  0, 0, 1);
        add(0, 0, D,            8'h00, 8'hFF, 1, 0, 0,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'h85, 0, 0, 0,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'h85, 3, 2, 2,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'h85, 4, 7, 7,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'h85, 4, 0, 0,  0, 0, 1);
        add(0, 0, D,            8'h00, 8'h85, 1, 0, 0,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'h85, 3, 2, 2,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'h85, 4, 7, 7,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'h85, 4, 0, 0,  0, 0, 1);
        add(0, 0, D,            8'h00, 8'h85, 1, 0, 0,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'h00, 0, 0, 0,  0, 1, 0);
        add(0, 0, D,            8'h00, 8'h00, 3, 0, 0,  0, 1, 0);
        add(0, 0, D,            8'h00, 8'h00, 4, 0, 0,  0, 1, 0);
        add(0, 0, D,            8'h00, 8'h01, 0, 0, 0,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'h01, 4, 0, 0,  0, 0, 1);
        add(0, 0, D,            8'h00, 8'h01, 1, 0, 0,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFE, 0, 0, 0,  0, 1, 0);
        add(0, 0, D,            8'h00, 8'hFE, 3, 1, 1,  0, 0, 0);
        add(0, 1, D,            8'h04, 8'hFF, 1, 1, 1,  0, 0, 0);
        add(0, 0, D,            8'h04, 8'hFF, 3, 2, 2,  1, 0, 0);
        add(0, 0, D,            8'h04, 8'hFF, 4, 3, 3,  0, 0, 0);
        add(0, 0, D,            8'h04, 8'hFF, 3, 3, 3,  0, 0, 0);
        add(0, 1, 32'hFFFF_FFFF, 8'h04, 8'hFF, 1, 4, 15, 0, 0, 0);
        add(0, 0, D,            8'h04, 8'hFF, 4, 5, 15, 0, 0, 0);
        add(0, 0, D,            8'h04, 8'hFF, 2, 5, 15, 0, 0, 0);
        add(1, 1, 32'h1234_5678, 8'hFF, 8'hFF, 1, 0, 0,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 3, 0, 0,  0, 0, 0);
        add(0, 0, D,            8'h00, 8'hFF, 1, 1, 0,  0, 0, 0);

        foreach (vecs[i]) begin
            reset         = vecs[i].rst;
            bus.load      = vecs[i].ld;
            bus.load_data = vecs[i].data;
            bus.load_dp   = vecs[i].dp;
            bus.digit_en  = vecs[i].en;
            if (vecs[i].ncyc == 0) begin
                #2;
            end else begin
                @(posedge clk);
                #1;
                reset    = 1'b0;
                bus.load = 1'b0;
                for (int k = 1; k < vecs[i].ncyc; k++) @(posedge clk);
                if (vecs[i].ncyc > 1) #2; else #1;
            end
            chk($sformatf("v%0d.active_digit", i), 32'(bus.active_digit), 32'(vecs[i].e_act));
            chk($sformatf("v%0d.num", i),          32'(bus.num),          32'(vecs[i].e_num));
            chk($sformatf("v%0d.dp_ctrl", i),      32'(bus.dp_ctrl),      32'(vecs[i].e_dp));
            chk($sformatf("v%0d.blank", i),        32'(bus.blank),        32'(vecs[i].e_blank));
            chk($sformatf("v%0d.frame_done", i),   32'(bus.frame_done),   32'(vecs[i].e_fd));
        end

        // Full frame from ptr=1 on a dwell boundary: exactly one wrap pulse, back at ptr=1.
        fd_cnt = 0;
        repeat (32) begin
            @(posedge clk);
            #2;
            if (bus.frame_done) fd_cnt++;
        end
        chk("frame_pulses_per_scan", 32'(fd_cnt), 32'd1);
        chk("ptr_after_full_scan", 32'(bus.active_digit), 32'd1);

        // Changing the mask mid-dwell must not restart the dwell.
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.digit_en = 8'hF0;
        #1;
        chk("mask_change_blank", 32'(bus.blank), 32'd1);
        chk("mask_change_ptr_hold", 32'(bus.active_digit), 32'd1);
        @(posedge clk);
        #2;
        chk("dwell_cycle3_ptr", 32'(bus.active_digit), 32'd1);
        @(posedge clk);
        #2;
        chk("dwell_tick_ptr", 32'(bus.active_digit), 32'd4);
        chk("dwell_tick_blank", 32'(bus.blank), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_controller.md
SSEG_SCAN_CONTROLLER -- requirements
Module: sseg_scan_controller

Interface
REQ-001 Parameter: TICK_DIV, default 100000, clk cycles per digit dwell; legal range is 2 to 2^24.
REQ-002 Port: clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset, input, 1, synchronous active-high reset.
REQ-004 Port: load, input, 1, strobe that captures load_data and load_dp on the same edge.
REQ-005 Port: load_data, input, 32, eight hex nibbles; nibble k is bits [4k+3:4k] and belongs to digit k.
REQ-006 Port: load_dp, input, 8, decimal-point bits; bit k belongs to digit k, and 1 means lit.
REQ-007 Port: digit_en, input, 8, live enable mask; bit k=1 includes digit k in the scan.
REQ-008 Port: active_digit, output, 3, index of the digit currently driven, for the sseg driver's digit select.
REQ-009 Port: num, output, 4, hex value of the current digit, for the sseg driver's num input.
REQ-010 Port: dp_ctrl, output, 1, decimal-point control for the current digit.
REQ-011 Port: blank, output, 1, set to 1 when no digit may be lit; downstream gates the anodes with it.
REQ-012 Port: frame_done, output, 1, one-cycle pulse at each scan wrap.

Function
REQ-013 Registered state SHALL be:
- prescaler cnt, 24 bits
- digit pointer ptr, 3 bits
- data_reg, 32 bits
- dp_reg, 8 bits
- frame_done flop
REQ-014 cnt SHALL count 0..TICK_DIV-1 and then wrap to 0; tick is the cycle where cnt==TICK_DIV-1.
REQ-015 On a tick edge, ptr SHALL move to the next index above ptr, searching with wrap 7->0, whose digit_en bit is 1.
REQ-016 If the only enabled digit is ptr itself, ptr SHALL hold on a tick.
REQ-017 If digit_en==0, ptr SHALL hold on a tick.
REQ-018 Between ticks, ptr SHALL hold.
REQ-019 Outputs SHALL be driven combinationally from the registers and digit_en:
- active_digit = ptr
- num = data_reg[4*ptr+3 : 4*ptr]
- dp_ctrl = dp_reg[ptr]
REQ-020 blank SHALL equal NOT digit_en[ptr], which is 1 whenever digit_en==0.
REQ-021 A digit_en change that disables the current ptr SHALL raise blank in the same cycle; ptr SHALL stay unchanged until the next tick.
REQ-022 When load=1 at an edge, data_reg and dp_reg SHALL capture their inputs; num and dp_ctrl SHALL show the new values from the next cycle.
REQ-023 load SHALL need no handshake, and back-to-back loads SHALL each be captured.
REQ-024 When load and tick fall on the same edge, both SHALL take effect: the next cycle shows the new data at the new ptr.
REQ-025 frame_done SHALL be 1 for exactly the cycle after a tick edge where the new ptr is less than or equal to the old ptr and digit_en!=0; it SHALL be 0 otherwise.
REQ-026 With a single enabled digit, frame_done SHALL pulse on every tick.
REQ-027 Changing digit_en SHALL NOT reset cnt; the dwell period stays uniform.

Reset
REQ-028 When reset=1 at an edge, the block SHALL clear:
- cnt=0, ptr=0
- data_reg=0, dp_reg=0
- frame_done=0
REQ-029 After reset: active_digit=0, num=0, dp_ctrl=0, and blank = NOT digit_en[0].
REQ-030 Reset SHALL take priority over load and tick in the same cycle.
REQ-031 Reset asserted mid-scan SHALL abort the dwell; the first tick comes TICK_DIV cycles after reset deasserts.

Verification (TICK_DIV=4)
REQ-032 Full scan:
- stimulus: reset; load_data=0x76543210, digit_en=0xFF
- response: active_digit steps 0..7 then back to 0, one step every 4 cycles; num==active_digit throughout; frame_done is a single pulse as ptr goes 7->0.
REQ-033 Skip disabled digits:
- stimulus: digit_en=8'b1000_0101
- response: ptr sequence 0,2,7,0,2; blank=0 throughout; frame_done pulses after each 7->0.
REQ-034 All digits disabled:
- stimulus: digit_en=0x00
- response: blank=1; ptr frozen; frame_done never pulses.
- then: setting digit_en=0x01 gives blank=0 in the same cycle.
REQ-035 Load on a tick edge:
- stimulus: load=1 with load_data=0xFFFFFFFF on the tick edge where ptr goes 3->4
- response: the next cycle shows active_digit=4, num=0xF.
REQ-036 Decimal point:
- stimulus: load_dp=0x04, digit_en=0xFF
- response: dp_ctrl=1 only while active_digit=2.
REQ-037 Reset mid-scan:
- stimulus: reset pulsed while ptr=5 and load=1
- response: the next cycle shows active_digit=0, num=0, dp_ctrl=0; the first advance comes 4 cycles after reset release.
